// File: rtl/axis_averager.sv
// -----------------------------------------------------------------------------
// axis_averager
//
// Block averager for a signed AXI-Stream sample stream. It sums 2^L input
// beats and emits one output beat equal to the sum arithmetically shifted
// right by L. L is log_count clamped to MAX_LOG_COUNT. It is latched on the
// first beat of each block, so a change mid-block applies to the next block.
//
// Optional feature macro: AXIS_AVERAGER_ROUND_EN
//   defined   : for L>0, add 2^(L-1) before the shift (round half up)
//   undefined : plain arithmetic shift (truncate toward negative infinity)
//
// Ports
//   aclk           in   clock, rising edge
//   areset         in   asynchronous active-high reset
//   enable         in   run averaging; low stalls input and drops partial block
//   log_count[4:0] in   log2 of samples per output (clamped)
//   S_AXIS_tdata   in   signed input sample
//   S_AXIS_tvalid  in   input valid
//   S_AXIS_tready  out  input ready (combinational)
//   M_AXIS_tdata   out  signed averaged sample (registered)
//   M_AXIS_tvalid  out  output valid (registered)
//   M_AXIS_tready  in   output ready
// -----------------------------------------------------------------------------
module axis_averager #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_LOG_COUNT    = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        enable,
    input  logic [4:0]                  log_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready
);

    localparam int         ACC_W = AXIS_TDATA_WIDTH + MAX_LOG_COUNT;
    localparam int         CNT_W = (MAX_LOG_COUNT > 0) ? MAX_LOG_COUNT : 1;
    localparam logic [4:0] MAX_L = 5'(MAX_LOG_COUNT);
`ifdef AXIS_AVERAGER_ROUND_EN
    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [4:0]                    l_q, l_d;
    logic                          m_valid_q, m_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0]   m_data_q, m_data_d;

    logic [4:0]                    l_clamp_s;
    logic [4:0]                    l_eff_s;
    logic                          first_beat_s;
    logic [CNT_W:0]                cnt_span_s;
    logic                          last_s;
    logic                          beat_s;
    logic signed [ACC_W-1:0]       raw_sum_s;
    logic signed [ACC_W-1:0]       rnd_sum_s;

    // Effective block length, last-beat detect and the running/rounded sums.
    always_comb begin
        l_clamp_s    = (log_count > MAX_L) ? MAX_L : log_count;
        first_beat_s = (cnt_q == {CNT_W{1'b0}});
        // The block length is taken live on the first beat, latched afterwards.
        l_eff_s      = first_beat_s ? l_clamp_s : l_q;
        cnt_span_s   = ({{CNT_W{1'b0}}, 1'b1} << l_eff_s) - {{CNT_W{1'b0}}, 1'b1};
        last_s       = ({1'b0, cnt_q} == cnt_span_s);
        beat_s       = S_AXIS_tvalid & S_AXIS_tready;
        raw_sum_s    = acc_q + {{MAX_LOG_COUNT{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
`ifdef AXIS_AVERAGER_ROUND_EN
        if (l_eff_s != 5'd0) begin
            rnd_sum_s = raw_sum_s + (ACC_ONE << (l_eff_s - 5'd1));
        end else begin
            rnd_sum_s = raw_sum_s;
        end
`else
        rnd_sum_s    = raw_sum_s;
`endif
    end

    // Next accumulator, counter, latched length and output register values.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        l_d       = l_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (!enable) begin
            // Disabling drops the partial block; a pending output survives.
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (beat_s) begin
            if (first_beat_s) begin
                l_d = l_clamp_s;
            end else begin
                l_d = l_q;
            end
            if (last_s) begin
                // Clear in the same edge so the next beat opens a new block.
                acc_d = {ACC_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
            end else begin
                acc_d = raw_sum_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            acc_d = acc_q;
        end

        // A new result may replace one being accepted in the same cycle.
        if (beat_s && last_s) begin
            m_valid_d = 1'b1;
            m_data_d  = AXIS_TDATA_WIDTH'(rnd_sum_s >>> l_eff_s);
        end else if (M_AXIS_tready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Next-state logic: IDLE while disabled, HOLD while an output is pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = m_valid_d ? ST_HOLD : ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM, ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (m_valid_d) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: input ready is forced low during reset.
    always_comb begin
        S_AXIS_tready = enable & ~areset & (~m_valid_q | M_AXIS_tready);
        M_AXIS_tvalid = m_valid_q;
        M_AXIS_tdata  = m_data_q;
    end

    // State register and datapath flops.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            l_q       <= 5'd0;
            m_valid_q <= 1'b0;
            m_data_q  <= {AXIS_TDATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            l_q       <= l_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: doc/axis_averager.md
AXIS_AVERAGER -- requirements
Module: axis_averager

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, which is the signed sample width on both streams.
REQ-002 The block SHALL have parameter MAX_LOG_COUNT, default 16, which is the largest supported log2 of the block length.
REQ-003 aclk  input  1  is the single clock; all logic is rising-edge.
REQ-004 areset  input  1  is the reset, asynchronous and active-high.
REQ-005 enable  input  1  runs averaging when high; when low it stalls input and discards the partial block.
REQ-006 log_count  input  5  is log2 of the samples per output; values above MAX_LOG_COUNT SHALL be clamped to MAX_LOG_COUNT.
REQ-007 S_AXIS_tdata  input  AXIS_TDATA_WIDTH  is the signed input sample from the differentiator output.
REQ-008 S_AXIS_tvalid  input  1  is the input valid.
REQ-009 S_AXIS_tready  output  1  is the input ready.
REQ-010 M_AXIS_tdata  output  AXIS_TDATA_WIDTH  is the signed averaged sample.
REQ-011 M_AXIS_tvalid  output  1  is the output valid.
REQ-012 M_AXIS_tready  input  1  is the output ready.

Function
REQ-013 An input beat SHALL be accepted when S_AXIS_tvalid and S_AXIS_tready are both high on a rising edge.
REQ-014 S_AXIS_tready SHALL equal enable AND (NOT M_AXIS_tvalid OR M_AXIS_tready), combinationally.
REQ-015 The accumulator SHALL be signed, AXIS_TDATA_WIDTH+MAX_LOG_COUNT bits wide, and sum sign-extended inputs without overflow.
REQ-016 The effective log_count L SHALL be sampled on the first accepted beat of each block and held until the block completes.
REQ-017 The sample counter SHALL increment on each accepted beat; the beat where the counter equals 2^L-1 SHALL be the last beat of the block.
REQ-018 On the last beat, M_AXIS_tdata SHALL load (acc + tdata) arithmetically shifted right by L and truncated to AXIS_TDATA_WIDTH, and M_AXIS_tvalid SHALL go high on the next edge.
REQ-019 On the last beat, the accumulator and counter SHALL clear in the same edge so that the next beat starts a new block with no lost cycle.
REQ-020 Latency SHALL be one cycle from the acceptance of the last beat to M_AXIS_tvalid high.
REQ-021 With L=0, the block SHALL be a one-cycle registered pass-through with throughput of one beat per cycle.
REQ-022 M_AXIS_tvalid and M_AXIS_tdata SHALL hold stable while M_AXIS_tvalid is high and M_AXIS_tready is low.
REQ-023 M_AXIS_tvalid SHALL clear on acceptance of the output, unless a new last beat is accepted in the same cycle, in which case it SHALL stay high with the new data.
REQ-024 State SHALL be IDLE (enable low), ACCUM (partial block), or HOLD (output pending, not accepted).
REQ-025 Transitions: enable falling goes from any state to IDLE, clearing acc and counter; a pending output SHALL remain valid until accepted.
REQ-026 A change of log_count mid-block SHALL take effect only at the next block start.

Reset
REQ-027 While areset is high, M_AXIS_tvalid=0, M_AXIS_tdata=0, accumulator=0, counter=0, latched L=0, and state=IDLE.
REQ-028 S_AXIS_tready SHALL be 0 during reset regardless of enable.
REQ-029 Asserting areset mid-block SHALL discard the partial sum and any pending output.
REQ-030 The first block after release SHALL start on the first accepted beat.

Configuration
REQ-031 With macro AXIS_AVERAGER_ROUND_EN defined, for L>0 the block SHALL add 2^(L-1) to the sum before the shift (round half up).
REQ-032 Without AXIS_AVERAGER_ROUND_EN, the shift SHALL truncate toward negative infinity.

Verification
REQ-033 Reset then L=2, inputs 1,2,3,4 continuous, tready=1 -> one output 2 (truncated; 3 with ROUND_EN) one cycle after the 4th beat.
REQ-034 L=1, inputs -3,-4 -> output -4 (truncated; -3 with ROUND_EN); inputs 0x7FFFFFFF twice -> 0x7FFFFFFF, no overflow.
REQ-035 L=0, ramp 0..9 with tvalid toggling every cycle -> outputs 0..9 each one cycle after acceptance, no drops.
REQ-036 L=1, M_AXIS_tready=0 for 5 cycles after the first output -> S_AXIS_tready low, output stable; release -> next pair averaged correctly.
REQ-037 L=3, drop enable after 5 beats then re-enable -> no output from the partial block; the next 8 beats of value 8 -> output 8.
REQ-038 Change log_count from 2 to 1 after 2 beats of a block -> the block still completes after 4 beats; the next block uses 2 beats.
